// File: rtl/seq_gen_pkg.sv
// rtl/seq_gen_pkg.sv - shared types and constants for the symbol sequence generator
//
// Holds the FSM state encoding, the symbol width and the default idle symbol
// used by seq_gen and its bus interface.
package seq_gen_pkg;

    localparam int SYM_W = 2;

    localparam logic [SYM_W-1:0] IDLE_SYM_DEF = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        FIN  = 2'd3
    } state_t;

endpackage

// File: rtl/seq_gen_if.sv
// rtl/seq_gen_if.sv - control/pattern/symbol bundle for seq_gen
//
// Signals:
//   load, load_sym[2*DEPTH], load_len[LW]  pattern capture (IDLE only)
//   start, rep[4]                          begin transmission, passes minus 1
//   abort                                  terminate transmission
//   sym[2], sym_vld, busy, done            registered generator outputs
// master: the controller driving commands; slave: the generator.
interface seq_gen_if #(
    parameter int DEPTH = 8
) ();
    import seq_gen_pkg::*;

    localparam int LW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic                   load;
    logic [SYM_W*DEPTH-1:0] load_sym;
    logic [LW-1:0]          load_len;
    logic                   start;
    logic [3:0]             rep;
    logic                   abort;
    logic [SYM_W-1:0]       sym;
    logic                   sym_vld;
    logic                   busy;
    logic                   done;

    modport master (
        output load, load_sym, load_len, start, rep, abort,
        input  sym, sym_vld, busy, done
    );

    modport slave (
        input  load, load_sym, load_len, start, rep, abort,
        output sym, sym_vld, busy, done
    );

endinterface

// File: rtl/seq_gen.sv
// rtl/seq_gen.sv - repeating 2-bit symbol pattern generator
//
// Ports:
//   clk    in   rising-edge clock
//   clr_n  in   asynchronous active-low reset
//   bus    slave modport of seq_gen_if (load/start/abort in, sym/sym_vld/busy/done out)
// Parameters:
//   DEPTH     maximum symbols per pattern
//   IDLE_SYM  symbol driven whenever sym_vld is low
//   GAP_EN    1 inserts one idle cycle between repeated passes
module seq_gen
    import seq_gen_pkg::*;
#(
    parameter int               DEPTH    = 8,
    parameter logic [SYM_W-1:0] IDLE_SYM = IDLE_SYM_DEF,
    parameter bit               GAP_EN   = 1'b1
) (
    input  logic        clk,
    input  logic        clr_n,
    seq_gen_if.slave    bus
);

    localparam int LW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t                 state;
    logic [SYM_W*DEPTH-1:0] pat_r;
    logic [LW-1:0]          len_r;
    logic [3:0]             rep_r;
    logic [3:0]             pass_r;
    logic [LW-1:0]          idx_r;     // index of the symbol currently on sym
    logic [SYM_W-1:0]       sym_r;
    logic                   vld_r;
    logic                   busy_r;
    logic                   done_r;

    logic [LW-1:0]          idx_nxt;
    logic [SYM_W-1:0]       sym_first;
    logic [SYM_W-1:0]       sym_next;

    assign idx_nxt   = idx_r + 1'b1;
    assign sym_first = pat_r[SYM_W-1:0];
    // Only used while idx_r < len_r, so idx_nxt never exceeds DEPTH-1.
    assign sym_next  = pat_r[SYM_W*int'(idx_nxt) +: SYM_W];

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state  <= IDLE;
            pat_r  <= '0;
            len_r  <= '0;
            rep_r  <= '0;
            pass_r <= '0;
            idx_r  <= '0;
            sym_r  <= IDLE_SYM;
            vld_r  <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    // load wins over a simultaneous start
                    if (bus.load) begin
                        pat_r <= bus.load_sym;
                        len_r <= bus.load_len;
                    end else if (bus.start) begin
                        rep_r  <= bus.rep;
                        pass_r <= '0;
                        idx_r  <= '0;
                        sym_r  <= sym_first;
                        vld_r  <= 1'b1;
                        busy_r <= 1'b1;
                        state  <= SEND;
                    end
                end

                SEND: begin
                    if (bus.abort) begin
                        sym_r  <= IDLE_SYM;
                        vld_r  <= 1'b0;
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end else if (idx_r == len_r) begin
                        if (pass_r == rep_r) begin
                            sym_r  <= IDLE_SYM;
                            vld_r  <= 1'b0;
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                            state  <= FIN;
                        end else begin
                            pass_r <= pass_r + 4'd1;
                            idx_r  <= '0;
                            if (GAP_EN) begin
                                sym_r <= IDLE_SYM;
                                vld_r <= 1'b0;
                                state <= GAP;
                            end else begin
                                sym_r <= sym_first;
                            end
                        end
                    end else begin
                        idx_r <= idx_nxt;
                        sym_r <= sym_next;
                    end
                end

                GAP: begin
                    if (bus.abort) begin
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        sym_r <= sym_first;
                        vld_r <= 1'b1;
                        state <= SEND;
                    end
                end

                FIN: begin
                    state <= IDLE;
                end

                default: begin
                    sym_r  <= IDLE_SYM;
                    vld_r  <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.sym     = sym_r;
    assign bus.sym_vld = vld_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;

endmodule
